// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS layout and the bit-timing FSM state type.
package uart_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DIV_W  = 16;

  localparam logic [1:0] UART_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_REG_DIV    = 2'd2;

  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_EMPTY     = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_COUNT_LSB = 8;

  // STATUS word as seen on the bus; field order matches the ST_* positions
  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  count;
    logic [3:0]  rsvd_lo;
    logic        ovf;
    logic        empty;
    logic        full;
    logic        busy;
  } uart_status_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

endpackage

// File: rtl/uart_tx_mmap_if.sv
// mmu device-port bus between the SoC interconnect and the UART peripheral.
interface uart_tx_mmap_if;
  import uart_pkg::*;

  logic              re;
  logic              we;
  logic [DATA_W-1:0] wd;
  logic [31:2]       addr;
  logic [DATA_W-1:0] rd;

  modport master (output re, output we, output wd, output addr, input rd);
  modport slave  (input re, input we, input wd, input addr, output rd);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers so full and empty are distinct.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             push_ok;
  logic             pop_ok;

  // a push into a full FIFO is dropped even when a pop happens in the same cycle
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign count = wptr - rptr;
  assign full  = (count == CW'(DEPTH));
  assign empty = (wptr == rptr);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + CW'(1);
      if (pop_ok)  rptr <= rptr + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_mmap.sv
// Memory-mapped 8N1 UART transmitter: CPU pushes bytes into a FIFO, a
// bit-timing FSM serialises them on tx using a programmable divisor.
module uart_tx_mmap
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = 278
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmap_if.slave  bus,
  output logic           tx
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        reg_sel;
  logic              wr_data;
  logic              wr_status;
  logic              wr_div;

  logic              fifo_pop;
  logic [BYTE_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  logic              ovf;
  logic [DIV_W-1:0]  divisor;

  uart_tx_state_t    state, state_d;
  logic [DIV_W-1:0]  bit_div, bit_div_d;
  logic [DIV_W-1:0]  timer, timer_d;
  logic [2:0]        bit_idx, bit_idx_d;
  logic [BYTE_W-1:0] shreg, shreg_d;
  logic              tx_d;
  logic              start_frame;

  uart_status_t      status;
  logic              unused_bits;

  assign reg_sel   = bus.addr[3:2];
  assign wr_data   = bus.we && (reg_sel == UART_REG_DATA);
  assign wr_status = bus.we && (reg_sel == UART_REG_STATUS);
  assign wr_div    = bus.we && (reg_sel == UART_REG_DIV);

  assign unused_bits = ^{bus.wd[31:16], bus.addr[31:4]};

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (wr_data),
    .pop   (fifo_pop),
    .wdata (bus.wd[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // sticky overflow wins over a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf     <= 1'b0;
      divisor <= DIV_W'(DEFAULT_DIV);
    end else begin
      ovf <= (wr_data && fifo_full) || (ovf && !(wr_status && bus.wd[ST_OVF]));
      if (wr_div) divisor <= (bus.wd[15:0] == '0) ? DIV_W'(1) : bus.wd[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_div <= DIV_W'(DEFAULT_DIV);
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      bit_div <= bit_div_d;
      timer   <= timer_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      tx      <= tx_d;
    end
  end

  // next-state logic; tx is registered from the state being entered
  always_comb begin
    state_d     = state;
    bit_div_d   = bit_div;
    timer_d     = timer;
    bit_idx_d   = bit_idx;
    shreg_d     = shreg;
    start_frame = 1'b0;
    tx_d        = 1'b1;

    unique case (state)
      IDLE: begin
        if (!fifo_empty) start_frame = 1'b1;
      end
      START: begin
        if (timer == '0) begin
          state_d   = DATA;
          bit_idx_d = '0;
          timer_d   = bit_div - DIV_W'(1);
        end else begin
          timer_d = timer - DIV_W'(1);
        end
      end
      DATA: begin
        if (timer == '0) begin
          timer_d = bit_div - DIV_W'(1);
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shreg_d   = {1'b0, shreg[7:1]};
          end
        end else begin
          timer_d = timer - DIV_W'(1);
        end
      end
      STOP: begin
        if (timer == '0) begin
          if (!fifo_empty) start_frame = 1'b1;
          else             state_d     = IDLE;
        end else begin
          timer_d = timer - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // divisor is sampled only here, so mid-frame writes apply to the next frame
    if (start_frame) begin
      state_d   = START;
      shreg_d   = fifo_rdata;
      bit_div_d = divisor;
      timer_d   = divisor - DIV_W'(1);
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign fifo_pop = start_frame;

  always_comb begin
    status        = '0;
    status.busy   = (state != IDLE) || !fifo_empty;
    status.full   = fifo_full;
    status.empty  = fifo_empty;
    status.ovf    = ovf;
    status.count  = 8'(fifo_count);
  end

  // zero-latency read mux
  always_comb begin
    bus.rd = '0;
    if (bus.re) begin
      case (reg_sel)
        UART_REG_STATUS: bus.rd = status;
        UART_REG_DIV:    bus.rd = DATA_W'(divisor);
        default:         bus.rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmap.sv
// Directed bench for uart_tx_mmap with a 4-clock default divisor.
module tb_uart_tx_mmap;
  import uart_pkg::*;

  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx;

  int total = 0;
  int bad   = 0;

  uart_tx_mmap_if bus ();

  uart_tx_mmap #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic rd_reg(input logic [1:0] idx, output logic [31:0] d);
    bus.addr = 30'(idx);
    bus.re   = 1'b1;
    #1;
    d        = bus.rd;
    bus.re   = 1'b0;
  endtask

  task automatic wr_reg(input logic [1:0] idx, input logic [31:0] d);
    bus.addr = 30'(idx);
    bus.wd   = d;
    bus.we   = 1'b1;
    @(posedge clk);
    #1;
    bus.we   = 1'b0;
  endtask

  // expected line levels of one 8N1 frame placed at offset off
  function automatic logic [511:0] put_frame(input logic [511:0] v, input int off,
                                             input logic [7:0] b, input int div);
    logic [511:0] r;
    logic         lvl;
    r = v;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      lvl = 1'b0;
      else if (k == 9) lvl = 1'b1;
      else             lvl = b[k-1];
      for (int j = 0; j < div; j++) r[off + k*div + j] = lvl;
    end
    return r;
  endfunction

  task automatic test_reset;
    logic [31:0] d;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx_held: got %b want 1", tx); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    rd_reg(UART_REG_STATUS, d);
    total++; if (d !== 32'h0000_0004) begin bad++; $display("FAIL reset_status: got %h want 00000004", d); end
    rd_reg(UART_REG_DIV, d);
    total++; if (d !== 32'd4) begin bad++; $display("FAIL reset_div: got %h want 00000004", d); end
    bus.addr = 30'(UART_REG_DIV);
    #1;
    total++; if (bus.rd !== 32'd0) begin bad++; $display("FAIL rd_idle: got %h want 00000000", bus.rd); end
    rd_reg(UART_REG_DATA, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL data_read: got %h want 00000000", d); end
  endtask

  task automatic test_single;
    logic [511:0] v, e;
    logic [31:0]  d;
    v = '1;
    e = put_frame('1, 0, 8'hA5, DIV);
    wr_reg(UART_REG_DATA, 32'h0000_00A5);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_pre: got %b want 1", tx); end
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      v[i] = tx;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 40; i++) begin
      total++; if (v[i] !== e[i]) begin bad++; $display("FAIL single_line[%0d]: got %b want %b", i, v[i], e[i]); end
    end
    rd_reg(UART_REG_STATUS, d);
    total++; if (d !== 32'h0000_0004) begin bad++; $display("FAIL single_idle: got %h want 00000004", d); end
  endtask

  task automatic test_back_to_back;
    logic [7:0]   b [3];
    logic [511:0] v, e;
    logic [31:0]  d;
    b = '{8'h0F, 8'hF0, 8'h96};
    v = '1;
    e = '1;
    for (int f = 0; f < 3; f++) e = put_frame(e, f*40, b[f], DIV);
    for (int i = 0; i < 126; i++) begin
      if (i >= 2) v[i-2] = tx;
      if (i == 3) begin
        rd_reg(UART_REG_STATUS, d);
        total++; if (d !== 32'h0000_0201) begin bad++; $display("FAIL b2b_count2: got %h want 00000201", d); end
      end
      if (i == 42) begin
        rd_reg(UART_REG_STATUS, d);
        total++; if (d !== 32'h0000_0101) begin bad++; $display("FAIL b2b_count1: got %h want 00000101", d); end
      end
      if (i == 82) begin
        rd_reg(UART_REG_STATUS, d);
        total++; if (d !== 32'h0000_0005) begin bad++; $display("FAIL b2b_count0: got %h want 00000005", d); end
      end
      if (i == 122) begin
        rd_reg(UART_REG_STATUS, d);
        total++; if (d !== 32'h0000_0004) begin bad++; $display("FAIL b2b_idle: got %h want 00000004", d); end
      end
      if (i < 3) begin
        bus.addr = 30'(UART_REG_DATA);
        bus.wd   = {24'd0, b[i]};
        bus.we   = 1'b1;
      end else begin
        bus.we = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 124; i++) begin
      total++; if (v[i] !== e[i]) begin bad++; $display("FAIL b2b_line[%0d]: got %b want %b", i, v[i], e[i]); end
    end
  endtask

  task automatic test_overflow;
    logic [7:0]   b [10];
    logic [511:0] v, e;
    logic [31:0]  d;
    b = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'h3C, 8'hC3, 8'h7E, 8'h81, 8'hEE};
    v = '1;
    e = '1;
    for (int f = 0; f < 9; f++) e = put_frame(e, f*40, b[f], DIV);
    for (int i = 0; i < 403; i++) begin
      if (i >= 2 && i < 402) v[i-2] = tx;
      if (i == 10) begin
        rd_reg(UART_REG_STATUS, d);
        total++; if (d !== 32'h0000_080B) begin bad++; $display("FAIL ovf_set: got %h want 0000080b", d); end
      end
      if (i == 11) begin
        rd_reg(UART_REG_STATUS, d);
        total++; if (d !== 32'h0000_0803) begin bad++; $display("FAIL ovf_clear: got %h want 00000803", d); end
      end
      if (i == 402) begin
        rd_reg(UART_REG_STATUS, d);
        total++; if (d !== 32'h0000_0004) begin bad++; $display("FAIL ovf_idle: got %h want 00000004", d); end
      end
      if (i < 10) begin
        bus.addr = 30'(UART_REG_DATA);
        bus.wd   = {24'd0, b[i]};
        bus.we   = 1'b1;
      end else if (i == 10) begin
        bus.addr = 30'(UART_REG_STATUS);
        bus.wd   = 32'h0000_0008;
        bus.we   = 1'b1;
      end else begin
        bus.we = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 400; i++) begin
      total++; if (v[i] !== e[i]) begin bad++; $display("FAIL ovf_line[%0d]: got %b want %b", i, v[i], e[i]); end
    end
  endtask

  task automatic test_divisor;
    logic [511:0] v, e;
    logic [31:0]  d;
    wr_reg(UART_REG_DIV, 32'd0);
    rd_reg(UART_REG_DIV, d);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL div_zero: got %h want 00000001", d); end
    wr_reg(UART_REG_DIV, 32'hFFFF_0004);
    rd_reg(UART_REG_DIV, d);
    total++; if (d !== 32'd4) begin bad++; $display("FAIL div_restore: got %h want 00000004", d); end
    v = '1;
    e = put_frame('1, 0, 8'hC5, 4);
    e = put_frame(e, 40, 8'h3A, 6);
    for (int i = 0; i < 112; i++) begin
      if (i >= 2) v[i-2] = tx;
      if (i == 3) begin
        rd_reg(UART_REG_DIV, d);
        total++; if (d !== 32'd6) begin bad++; $display("FAIL div_mid: got %h want 00000006", d); end
      end
      bus.we = 1'b1;
      if (i == 0) begin
        bus.addr = 30'(UART_REG_DATA); bus.wd = 32'h0000_00C5;
      end else if (i == 1) begin
        bus.addr = 30'(UART_REG_DATA); bus.wd = 32'h0000_003A;
      end else if (i == 2) begin
        bus.addr = 30'(UART_REG_DIV);  bus.wd = 32'h0000_0006;
      end else begin
        bus.we = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 110; i++) begin
      total++; if (v[i] !== e[i]) begin bad++; $display("FAIL div_line[%0d]: got %b want %b", i, v[i], e[i]); end
    end
    wr_reg(UART_REG_DIV, 32'd4);
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    for (int i = 0; i < 12; i++) begin
      if (i < 3) begin
        bus.addr = 30'(UART_REG_DATA);
        bus.wd   = 32'h0000_0000;
        bus.we   = 1'b1;
      end else begin
        bus.we = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL rst_mid_pre: got %b want 0", tx); end
    reset = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_mid_async: got %b want 1", tx); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    rd_reg(UART_REG_STATUS, d);
    total++; if (d !== 32'h0000_0004) begin bad++; $display("FAIL rst_mid_status: got %h want 00000004", d); end
    for (int i = 0; i < 60; i++) begin
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_mid_quiet[%0d]: got %b want 1", i, tx); end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.re   = 1'b0;
    bus.we   = 1'b0;
    bus.wd   = '0;
    bus.addr = '0;
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_divisor;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmap.md
# uart_tx_mmap

Memory-mapped UART transmitter: a peripheral behind the `mmu` device port on the SoC bus, beside `led_mmap`. The CPU writes bytes into a small FIFO. A bit-timing state machine serialises them 8N1 on the `tx` pin. Status and baud divisor are exposed through a 16-byte register window (suggested map: `32'ha000_0020`–`32'ha000_002f`, `dev_rw = 1`).

## Interface

- `FIFO_DEPTH`, default 8: TX FIFO entries; power of two, ≥ 2.
- `DEFAULT_DIV`, default 278: reset value of DIVISOR, in clocks per bit (32 MHz / 115200).
- `clk`, in, 1: single clock; all state on rising edge.
- `reset`, in, 1: reset is asynchronous and active-low (asserted at 0). Can be driven directly from `btn`.
- `re`, in, 1: read strobe from mmu.
- `rd`, out, 32: read data; combinational from `addr`/registers while `re`=1, else 0.
- `we`, in, 1: write strobe from mmu; committed at the next rising edge.
- `wd`, in, 32: write data.
- `addr`, in, 30 (`[31:2]`): word address; only `addr[3:2]` decoded.
- `tx`, out, 1: serial line; idle high.

## Operation

- Register `addr[3:2]` = 0, DATA:
  - Write pushes `wd[7:0]` into the FIFO.
  - If the FIFO is full before the edge, the byte is dropped and the sticky `ovf` bit is set. This holds even if a pop occurs in the same cycle.
  - Read returns 0.
- Register 1, STATUS. Read returns:
  - `[0]` busy: FSM not IDLE or FIFO non-empty.
  - `[1]` full.
  - `[2]` empty.
  - `[3]` ovf.
  - `[15:8]` FIFO count.
  - All other bits are 0.
  - Write with `wd[3]`=1 clears ovf. A clear and a new overflow in the same cycle leave ovf=1.
- Register 2, DIVISOR:
  - Read returns the value in `[15:0]`, zero-extended.
  - Write loads `wd[15:0]`; a written 0 is stored as 1.
- Register 3: reserved; reads 0, writes ignored.
- FSM states:
  - IDLE (tx=1). If the FIFO is non-empty: pop the byte into the shift register, latch DIVISOR into `bit_div`, go to START.
  - START (tx=0) for `bit_div` clocks, then DATA.
  - DATA: 8 bits, LSB first, `bit_div` clocks each, bit index 0..7.
  - STOP (tx=1) for `bit_div` clocks. On the last stop clock, if the FIFO is non-empty, pop and go directly to START with no idle gap; else go to IDLE.
- Bit timer: 16-bit down-counter loaded with `bit_div-1` on each bit entry. The bit ends when the counter is 0.
- A DIVISOR write mid-frame affects only the next frame.
- FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits, so full and empty are distinguishable; they wrap modulo 2·DEPTH.
- Reset values:
  - `tx`=1, FSM=IDLE, FIFO empty (count 0).
  - ovf=0, DIVISOR=`DEFAULT_DIV`, `rd`=0.
- Reset asserted mid-frame aborts the frame immediately: `tx`=1 asynchronously, and all queued bytes are lost.

## Timing

- A DATA write accepted at edge N into an empty FIFO with FSM IDLE: the pop occurs at edge N+1 and `tx` falls after N+1.
- Frame length is exactly 10·`bit_div` clocks.
- Back-to-back frames: the next start bit begins the clock after the previous stop bit ends.
- Reads have zero latency (combinational). STATUS reflects state after the last edge; a push at edge N is visible in the read during cycle N+1.
- Push and pop in the same cycle on a non-full, non-empty FIFO: count unchanged.

## Structure

- Package `uart_pkg`:
  - register index localparams `UART_REG_DATA=0`, `UART_REG_STATUS=1`, `UART_REG_DIV=2`;
  - STATUS bit positions;
  - typedef enum `uart_tx_state_t {IDLE, START, DATA, STOP}`.
- Sub-module `sync_fifo`, parameterised by `WIDTH` and `DEPTH`, with ports `push/pop/wdata/rdata/full/empty/count`. `uart_tx_mmap` instantiates it with WIDTH=8.

## Test plan

- Reset checks, with the bench using `DEFAULT_DIV`=4:
  - Reset release → `tx`=1, STATUS read = `32'h0000_0004`, DIVISOR read = 4.
- Single frame:
  - Write DATA `8'hA5` → `tx` falls one clock after the write edge.
  - Line sequence is 0,1,0,1,0,0,1,0,1,1, each held 4 clocks.
  - Busy=0 after 40 clocks.
- Back-to-back:
  - Write 3 bytes in consecutive cycles → 120 contiguous clocks of framing with no idle gap.
  - Count reads 2, 1, 0 as each pop occurs.
- Overflow:
  - Fill the FIFO during a frame (1 popped + 8 queued), then write a 10th byte → ovf=1 and the 10th byte is never transmitted.
  - Write STATUS `32'h8` → ovf=0.
- Divisor:
  - Write DIVISOR=0 → reads 1.
  - Write DIVISOR=6 mid-frame → the current frame keeps 4-clock bits; the next frame uses 6.
- Reset during a DATA bit with 2 bytes queued → `tx`=1 immediately; after release, STATUS = `32'h4` and no further frames appear.
